// File: rtl/memory_stage_pkg.sv
// -----------------------------------------------------------------------------
// memory_stage_pkg
// Shared pipeline definitions for the memory stage:
//   - datapath and register-address widths
//   - bit positions inside the 3-bit control bundle coming from execute
//   - a decoded view of one memory-stage operation and the decode helper
// -----------------------------------------------------------------------------
package memory_stage_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_W      = 5;
    localparam int CTRL_W     = 3;

    localparam int CTRL_REGWR = 2;
    localparam int CTRL_MEMWR = 1;
    localparam int CTRL_MEMRD = 0;

    // Decoded operation. load/store are only set for legal control;
    // illegal (both memory bits set) is kept separate so it never
    // touches memory.
    typedef struct packed {
        logic reg_wr;
        logic load;
        logic store;
        logic illegal;
        logic misaligned;
    } mem_op_t;

    function automatic mem_op_t decode_op(input logic [CTRL_W-1:0] ctrl,
                                          input logic [1:0]        byte_off);
        mem_op_t op;
        op.reg_wr     = ctrl[CTRL_REGWR];
        op.illegal    = ctrl[CTRL_MEMWR] & ctrl[CTRL_MEMRD];
        op.load       = ctrl[CTRL_MEMRD] & ~ctrl[CTRL_MEMWR];
        op.store      = ctrl[CTRL_MEMWR] & ~ctrl[CTRL_MEMRD];
        op.misaligned = (op.load | op.store) & (byte_off != 2'b00);
        return op;
    endfunction

endpackage

// File: rtl/memory_stage_data_mem.sv
// -----------------------------------------------------------------------------
// memory_stage_data_mem
// Word-organised data memory: 2^ADDR_W x 32 bits, one synchronous write
// port and one asynchronous read port. No reset; contents are undefined
// until written.
// Ports:
//   clk_i    write clock
//   we_i     write enable (sampled on rising edge)
//   waddr_i  write word address
//   wdata_i  write data
//   raddr_i  read word address
//   rdata_o  combinational read data
// -----------------------------------------------------------------------------
module memory_stage_data_mem
    import memory_stage_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
// Fourth pipeline stage (between execute and writeback). Registers the
// execute result, performs word loads/stores against a local data memory
// and presents the result to writeback one cycle later. Also exposes the
// forwarding/hazard values for the instruction currently in this stage.
// Ports:
//   clk                      pipeline clock
//   rst                      synchronous active-high reset
//   exe_mem_reslt_data_out   ALU result / byte address from execute
//   exe_mem_wr_data          store data
//   exe_mem_reg_wr_add       destination register
//   exe_mem_ctrl_sgs         [2] reg write, [1] mem write, [0] mem read
//   mem_wb_reslt_data        registered load data or ALU result
//   mem_wb_reg_wr_add        registered destination register
//   mem_wb_ctrl_sgs          registered reg-write enable
//   mem_exe_reslt_data       ALU result for execute-stage forwarding
//   mem_hctrl_reg_wr_add_st  destination register for the hazard unit
//   mem_hctrl_ld             current instruction is a legal load
//   mem_err                  sticky misaligned/illegal-access flag
// -----------------------------------------------------------------------------
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] exe_mem_reslt_data_out,
    input  logic [DATA_W-1:0] exe_mem_wr_data,
    input  logic [REG_W-1:0]  exe_mem_reg_wr_add,
    input  logic [CTRL_W-1:0] exe_mem_ctrl_sgs,
    output logic [DATA_W-1:0] mem_wb_reslt_data,
    output logic [REG_W-1:0]  mem_wb_reg_wr_add,
    output logic              mem_wb_ctrl_sgs,
    output logic [DATA_W-1:0] mem_exe_reslt_data,
    output logic [REG_W-1:0]  mem_hctrl_reg_wr_add_st,
    output logic              mem_hctrl_ld,
    output logic              mem_err
);

    mem_op_t           op;
    logic [ADDR_W-1:0] word_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] reslt_d, reslt_q;
    logic [REG_W-1:0]  reg_add_d, reg_add_q;
    logic              reg_wr_d, reg_wr_q;
    logic              err_d, err_q;

    // Byte address -> word address; higher bits are dropped so the
    // address space wraps modulo 2^(ADDR_W+2).
    assign word_addr = exe_mem_reslt_data_out[ADDR_W+1:2];
    assign op        = decode_op(exe_mem_ctrl_sgs, exe_mem_reslt_data_out[1:0]);

    // Stores are blocked while in reset so an in-flight store is dropped.
    assign mem_we = op.store & ~op.misaligned & ~rst;

    memory_stage_data_mem #(
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (word_addr),
        .wdata_i (exe_mem_wr_data),
        .raddr_i (word_addr),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        reslt_d = exe_mem_reslt_data_out;
        if (op.load) begin
            reslt_d = op.misaligned ? '0 : mem_rdata;
        end
        reg_add_d = exe_mem_reg_wr_add;
        reg_wr_d  = op.reg_wr;
        err_d     = err_q | op.illegal | op.misaligned;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reslt_q   <= '0;
            reg_add_q <= '0;
            reg_wr_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            reslt_q   <= reslt_d;
            reg_add_q <= reg_add_d;
            reg_wr_q  <= reg_wr_d;
            err_q     <= err_d;
        end
    end

    assign mem_wb_reslt_data = reslt_q;
    assign mem_wb_reg_wr_add = reg_add_q;
    assign mem_wb_ctrl_sgs   = reg_wr_q;
    assign mem_err           = err_q;

    // Forwarding carries only the ALU result; a load in this stage must
    // be covered by a load-use stall in the hazard unit instead.
    assign mem_exe_reslt_data      = exe_mem_reslt_data_out;
    assign mem_hctrl_reg_wr_add_st = exe_mem_reg_wr_add;
    assign mem_hctrl_ld            = op.load;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

    logic        clk;
    logic        rst;
    logic [31:0] res_in;
    logic [31:0] wd_in;
    logic [4:0]  rd_in;
    logic [2:0]  ctrl_in;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_wr;
    logic [31:0] fwd_data;
    logic [4:0]  hz_rd;
    logic        hz_ld;
    logic        err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  r;
        logic        w;
        logic        e;
    } exp_t;

    exp_t sb_q[$];

    memory_stage #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .exe_mem_reslt_data_out  (res_in),
        .exe_mem_wr_data         (wd_in),
        .exe_mem_reg_wr_add      (rd_in),
        .exe_mem_ctrl_sgs        (ctrl_in),
        .mem_wb_reslt_data       (wb_data),
        .mem_wb_reg_wr_add       (wb_rd),
        .mem_wb_ctrl_sgs         (wb_wr),
        .mem_exe_reslt_data      (fwd_data),
        .mem_hctrl_reg_wr_add_st (hz_rd),
        .mem_hctrl_ld            (hz_ld),
        .mem_err                 (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one instruction for one cycle starting at a falling edge; queue
    // the hand-computed writeback view expected after the next rising edge.
    task automatic issue(input logic r, input logic [31:0] res, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [2:0] ctrl,
                         input logic [31:0] ed, input logic [4:0] erd,
                         input logic ew, input logic ee, input logic eld);
        exp_t e;
        rst = r; res_in = res; wd_in = wd; rd_in = rd; ctrl_in = ctrl;
        e.d = ed; e.r = erd; e.w = ew; e.e = ee;
        sb_q.push_back(e);
        #1;
        chk("fwd_data", fwd_data, res);
        chk("hz_rd", 32'(hz_rd), 32'(rd));
        chk("hz_ld", 32'(hz_ld), 32'(eld));
        @(negedge clk);
    endtask

    // Monitor: the stage produces a writeback value every cycle.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("wb_data", wb_data, e.d);
            chk("wb_rd", 32'(wb_rd), 32'(e.r));
            chk("wb_wr", 32'(wb_wr), 32'(e.w));
            chk("mem_err", 32'(err), 32'(e.e));
        end
    end

    initial begin
        rst = 1'b1; res_in = '0; wd_in = '0; rd_in = '0; ctrl_in = '0;
        @(negedge clk);

        // Reset with random inputs for two cycles
        for (int i = 0; i < 2; i++) begin
            logic [31:0] rr;
            logic [2:0]  rc;
            rr = $urandom;
            rc = 3'($urandom);
            issue(1'b1, rr, $urandom, 5'd1, rc, 32'h0, 5'd0, 1'b0, 1'b0,
                  rc[0] & ~rc[1]);
        end

        // Store before reset survives; store during reset is blocked
        issue(1'b0, 32'h40, 32'h1111_1111, 5'd5, 3'b010, 32'h40, 5'd5, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 32'h40, 32'h9999_9999, 5'd6, 3'b010, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 32'h40, 32'h0, 5'd2, 3'b001, 32'h1111_1111, 5'd2, 1'b0, 1'b0, 1'b1);

        // Store then back-to-back load
        issue(1'b0, 32'h10, 32'hDEAD_BEEF, 5'd0, 3'b010, 32'h10, 5'd0, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 32'h10, 32'h0, 5'd7, 3'b101, 32'hDEAD_BEEF, 5'd7, 1'b1, 1'b0, 1'b1);

        // ALU passthrough
        issue(1'b0, 32'h123, 32'hFFFF_FFFF, 5'd3, 3'b100, 32'h123, 5'd3, 1'b1, 1'b0, 1'b0);

        // Wrap-around: 0x400 aliases word 0
        issue(1'b0, 32'h400, 32'h55, 5'd0, 3'b010, 32'h400, 5'd0, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 32'h0, 32'h0, 5'd4, 3'b001, 32'h55, 5'd4, 1'b0, 1'b0, 1'b1);

        // Misaligned store: suppressed, error sticks
        issue(1'b0, 32'h13, 32'hAAAA, 5'd0, 3'b010, 32'h13, 5'd0, 1'b0, 1'b1, 1'b0);
        issue(1'b0, 32'h10, 32'h0, 5'd8, 3'b101, 32'hDEAD_BEEF, 5'd8, 1'b1, 1'b1, 1'b1);
        issue(1'b0, 32'h12, 32'h0, 5'd9, 3'b101, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1);
        issue(1'b0, 32'h77, 32'h0, 5'd1, 3'b100, 32'h77, 5'd1, 1'b1, 1'b1, 1'b0);

        // Reset clears the error
        issue(1'b1, 32'h0, 32'h0, 5'd0, 3'b000, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Illegal control: no write, ALU result passes, error set
        issue(1'b0, 32'h20, 32'h77, 5'd0, 3'b010, 32'h20, 5'd0, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 32'h20, 32'hBAD, 5'd9, 3'b111, 32'h20, 5'd9, 1'b1, 1'b1, 1'b0);
        issue(1'b0, 32'h20, 32'h0, 5'd10, 3'b001, 32'h77, 5'd10, 1'b0, 1'b1, 1'b1);

        rst = 1'b0; ctrl_in = 3'b000;
        @(posedge clk);
        #3;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Fourth stage of the five-stage pipeline, between execute and writeback. It registers the execute-stage result, performs word loads and stores against a local data memory, and presents the result to writeback one cycle later. It also drives the forwarding and hazard-control values the execute stage and hazard unit need for results currently in this stage.

## Interface
Parameters:
- ADDR_W, 8: word-address width; data memory holds 2^ADDR_W 32-bit words.

Ports:
- clk  input  1  pipeline clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- exe_mem_reslt_data_out  input  32  ALU result from execute; also the byte address for loads and stores.
- exe_mem_wr_data  input  32  store data.
- exe_mem_reg_wr_add  input  5  destination register.
- exe_mem_ctrl_sgs  input  3  control: [2] reg write, [1] mem write (store), [0] mem read (load).
- mem_wb_reslt_data  output  32  registered load data or ALU result, to writeback.
- mem_wb_reg_wr_add  output  5  registered destination register.
- mem_wb_ctrl_sgs  output  1  registered reg-write enable.
- mem_exe_reslt_data  output  32  combinational copy of exe_mem_reslt_data_out, for execute forwarding (mux select 1).
- mem_hctrl_reg_wr_add_st  output  5  combinational copy of exe_mem_reg_wr_add, for the hazard unit.
- mem_hctrl_ld  output  1  combinational: the current instruction is a valid load.
- mem_err  output  1  sticky access-error flag.

## Operation
- Word address: exe_mem_reslt_data_out[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 2^(ADDR_W+2).
- Misaligned access: a load or store with address bits [1:0] not equal to 0.
  - The store is suppressed.
  - The load result is 0.
  - mem_err is set.
- Illegal control: ctrl [1] and [0] both set.
  - No memory access occurs.
  - The result is the ALU result.
  - mem_err is set.
- Store (ctrl[1]=1, aligned, legal): mem[addr] is written with exe_mem_wr_data on the clock edge.
- Load (ctrl[0]=1, aligned, legal): mem[addr] is read combinationally and registered into mem_wb_reslt_data.
- Neither load nor store: mem_wb_reslt_data takes exe_mem_reslt_data_out.
- mem_wb_ctrl_sgs takes ctrl[2] unchanged. A store with ctrl[2]=1 is passed through; this block does not check it.
- Forwarding carries only the ALU result, never load data. The hazard unit must stall one cycle on load-use, using mem_hctrl_ld together with mem_hctrl_reg_wr_add_st.
- mem_err is sticky. Only rst clears it.

## Timing
- Latency is 1 cycle from inputs to mem_wb_* outputs.
- Store then load: a store at edge N is visible to a load presented in the cycle after edge N.
- Reset values (synchronous, on the edge where rst=1):
  - mem_wb_reslt_data = 0
  - mem_wb_reg_wr_add = 0
  - mem_wb_ctrl_sgs = 0
  - mem_err = 0
- Stores are blocked in any cycle with rst=1.
- Memory contents are not cleared by reset and are undefined until written. The bench initialises them by writing through stores.
- Reset arriving mid-sequence: the in-flight instruction is dropped and no write occurs in that cycle. Stores committed on earlier edges persist.
- The combinational outputs (mem_exe_reslt_data, mem_hctrl_reg_wr_add_st, mem_hctrl_ld) follow the inputs during reset.

## Structure
- Shared pipeline package holds:
  - control bit-index constants: CTRL_REGWR=2, CTRL_MEMWR=1, CTRL_MEMRD=0.
  - the 32-bit data width and 5-bit register-address width.
- One sub-module, data_mem:
  - 2^ADDR_W × 32 array.
  - one synchronous write port and one asynchronous read port.
  - no reset.
- memory_stage itself holds the decode, the error logic and the pipeline register.

## Test plan
- Reset: hold rst=1 for 2 cycles with random inputs -> all mem_wb_* outputs are 0, mem_err=0, and a subsequent load from the address of a store attempted during reset returns the prior contents.
- Store then load: store 0xDEADBEEF at address 0x10 (ctrl=3'b010), then load 0x10 with ctrl=3'b101, reg 7 -> next edge mem_wb_reslt_data=0xDEADBEEF, mem_wb_reg_wr_add=7, mem_wb_ctrl_sgs=1.
- ALU passthrough: ctrl=3'b100, result 0x00000123, reg 3 -> mem_wb_reslt_data=0x123 after 1 cycle; mem_exe_reslt_data=0x123 in the same cycle; mem_hctrl_ld=0.
- Wrap-around: store 0x55 at 0x400 (ADDR_W=8), then load 0x0 -> 0x55.
- Misaligned store: store 0xAAAA to 0x13 -> word 0x10 unchanged; mem_err=1 and remains 1 through later valid operations until rst.
- Illegal control: ctrl=3'b111 with result 0x20 -> no write to 0x20; mem_wb_reslt_data=0x20; mem_err=1.
